// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter and its helpers.
//   arb_state_t  : arbiter FSM state encoding
//   port_id_t    : identifies which requester owns the current access
//   BE_FULL/NONE : byte-enable patterns that select the fast write/no-op paths
//   be_is_partial: true when a write touches some but not all bytes
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    // A partial write needs a read-modify-write; full and empty patterns do not.
    function automatic logic be_is_partial(input logic [3:0] be);
        return (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/byte_merge.sv
// -----------------------------------------------------------------------------
// byte_merge
// Purely combinational byte-lane merge used for read-modify-write.
//   old_word : word currently held in memory
//   new_word : word supplied by the requester
//   be       : per-byte select, 1 = take the byte from new_word
//   merged   : resulting word
// -----------------------------------------------------------------------------
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = be[gi] ? new_word[gi*8 +: 8]
                                              : old_word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one single-cycle memory between two requesters
// (port 0: core load/store, port 1: loader/debug). Partial writes are turned
// into a read followed by a merged full-word write.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_pN_req/we/addr/wdata/be  request and payload per port (held until gnt)
//   o_pN_gnt                   combinational accept pulse, only in IDLE
//   o_pN_ack                   one-cycle completion pulse
//   o_pN_rdata                 last read data for the port (held)
//   o_mem_read_en/write_en     memory strobes, never both high
//   o_mem_addr                 word-aligned memory byte address
//   o_mem_wdata                memory write data
//   i_mem_rdata                memory read data, combinational from o_mem_addr
//
// Timing from grant cycle N: ACCESS at N+1, ACK at N+2 (N+3 via MERGE),
// IDLE again the cycle after ACK.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic [3:0]        i_p0_be,
    output logic              o_p0_gnt,
    output logic              o_p0_ack,
    output logic [DATA_W-1:0] o_p0_rdata,

    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    input  logic [3:0]        i_p1_be,
    output logic              o_p1_gnt,
    output logic              o_p1_ack,
    output logic [DATA_W-1:0] o_p1_rdata,

    output logic              o_mem_read_en,
    output logic              o_mem_write_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    import mem_arb_pkg::*;

    arb_state_t          state_reg, state_next;
    port_id_t            last_reg;     // port served most recently
    port_id_t            port_reg;     // owner of the access in flight
    logic                we_reg;
    logic [ADDR_W-3:0]   addr_reg;     // word address; byte offset dropped
    logic [DATA_W-1:0]   wdata_reg;
    logic [3:0]          be_reg;
    logic [DATA_W-1:0]   old_reg;      // pre-image for read-modify-write
    logic [DATA_W-1:0]   rdata0_reg;
    logic [DATA_W-1:0]   rdata1_reg;

    logic                grant;
    port_id_t            winner;
    logic                read_en;
    logic                write_en;
    logic [DATA_W-1:0]   merged_word;

    // Byte offset of the requester address is architecturally ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_p0_addr[1:0], i_p1_addr[1:0]};

    // -------------------------------------------------------------------------
    // Arbitration. Grants exist only in IDLE and are suppressed while reset is
    // asserted so no requester sees an accept that the FSM will not honour.
    // -------------------------------------------------------------------------
    always_comb begin
        grant  = 1'b0;
        winner = PORT0;
        if ((state_reg == ST_IDLE) && rst_n) begin
            if (i_p0_req && i_p1_req) begin
                grant  = 1'b1;
                winner = ~last_reg;
            end else if (i_p0_req) begin
                grant  = 1'b1;
                winner = PORT0;
            end else if (i_p1_req) begin
                grant  = 1'b1;
                winner = PORT1;
            end
        end
    end

    assign o_p0_gnt = grant && (winner == PORT0);
    assign o_p1_gnt = grant && (winner == PORT1);

    // -------------------------------------------------------------------------
    // Next-state and memory strobe decode.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        read_en    = 1'b0;
        write_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_reg) begin
                    read_en    = 1'b1;
                    state_next = ST_ACK;
                end else if (be_reg == BE_FULL) begin
                    write_en   = 1'b1;
                    state_next = ST_ACK;
                end else if (be_reg == BE_NONE) begin
                    state_next = ST_ACK;
                end else begin
                    // Partial write: fetch the old word first.
                    read_en    = 1'b1;
                    state_next = ST_MERGE;
                end
            end
            ST_MERGE: begin
                write_en   = 1'b1;
                state_next = ST_ACK;
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            last_reg   <= PORT1;     // port 0 wins the first tie
            port_reg   <= PORT0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            be_reg     <= BE_NONE;
            old_reg    <= '0;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (grant) begin
                last_reg  <= winner;
                port_reg  <= winner;
                we_reg    <= (winner == PORT1) ? i_p1_we    : i_p0_we;
                addr_reg  <= (winner == PORT1) ? i_p1_addr[ADDR_W-1:2]
                                               : i_p0_addr[ADDR_W-1:2];
                wdata_reg <= (winner == PORT1) ? i_p1_wdata : i_p0_wdata;
                be_reg    <= (winner == PORT1) ? i_p1_be    : i_p0_be;
            end

            if ((state_reg == ST_ACCESS) && read_en) begin
                if (we_reg) begin
                    old_reg <= i_mem_rdata;
                end else if (port_reg == PORT1) begin
                    rdata1_reg <= i_mem_rdata;
                end else begin
                    rdata0_reg <= i_mem_rdata;
                end
            end
        end
    end

    byte_merge u_byte_merge (
        .old_word (old_reg),
        .new_word (wdata_reg),
        .be       (be_reg),
        .merged   (merged_word)
    );

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign o_mem_read_en  = read_en;
    assign o_mem_write_en = write_en;
    assign o_mem_addr     = {addr_reg, 2'b00};
    assign o_mem_wdata    = (state_reg == ST_MERGE) ? merged_word : wdata_reg;

    assign o_p0_ack   = (state_reg == ST_ACK) && (port_reg == PORT0);
    assign o_p1_ack   = (state_reg == ST_ACK) && (port_reg == PORT1);
    assign o_p0_rdata = rdata0_reg;
    assign o_p1_rdata = rdata1_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, requester/memory address width.
REQ-002 Parameter: DATA_W, 32, data width; fixed at 32 because byte enables are 4 bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_p0_req / i_p1_req  input  1  access request, port 0 (core load/store) / port 1 (loader/debug).
REQ-006 i_pN_we  input  1  1 = write, 0 = read.
REQ-007 i_pN_addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-008 i_pN_wdata  input  32  write data.
REQ-009 i_pN_be  input  4  byte enables for writes; ignored on reads.
REQ-010 o_pN_gnt  output  1  one-cycle pulse when the port's request is accepted.
REQ-011 o_pN_ack  output  1  one-cycle completion pulse.
REQ-012 o_pN_rdata  output  32  read data, valid while o_pN_ack is high after a read.
REQ-013 o_mem_read_en / o_mem_write_en  output  1  memory strobes.
REQ-014 o_mem_addr  output  ADDR_W  memory byte address, with [1:0] forced to 0.
REQ-015 o_mem_wdata  output  32  memory write data.
REQ-016 i_mem_rdata  input  32  memory read data, combinational from o_mem_addr.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, MERGE and ACK; grants SHALL be issued only in IDLE.
REQ-018 In IDLE with any request high, the block SHALL assert the winner's o_pN_gnt combinationally in that cycle and capture its we, addr, wdata, be and port id.
- Next state: ACCESS.
REQ-019 Arbitration SHALL be round-robin via a last-served pointer.
- Single request: granted immediately.
- Both requesting: the port not served last wins.
- Pointer updates on grant.
REQ-020 Requesters SHALL hold req and payload stable until gnt, and drop req in the cycle after gnt unless issuing a new access.
REQ-021 ACCESS, read: o_mem_read_en=1; i_mem_rdata registered into o_pN_rdata; next state ACK.
REQ-022 ACCESS, write with be==4'hF: o_mem_write_en=1 with captured wdata; next state ACK.
REQ-023 ACCESS, write with be==4'h0: no strobe; next state ACK (no-op ack).
REQ-024 ACCESS, partial write (be other than 0 and F): o_mem_read_en=1; old word registered; next state MERGE.
REQ-025 MERGE: o_mem_write_en=1; o_mem_wdata per byte = captured wdata where be set, else the old word; next state ACK.
REQ-026 ACK: the captured port's o_pN_ack SHALL pulse for one cycle; next state IDLE.
REQ-027 Latency from gnt cycle N: read / full-word write / no-op ack at N+2; partial write ack at N+3; earliest next grant at N+3 (N+4 after a partial write).
REQ-028 o_pN_rdata SHALL hold its last value until the next read completes on that port.
REQ-029 At most one memory strobe SHALL be high in any cycle; both SHALL be low in IDLE and ACK.
REQ-030 A request arriving outside IDLE SHALL wait; it SHALL be neither dropped nor granted early.

Reset
REQ-031 While rst_n is low, asynchronously:
- state = IDLE; last-served pointer = port 1, so port 0 wins the first tie.
- all gnt, ack and mem strobes = 0; o_mem_addr, o_mem_wdata and o_pN_rdata = 0.
REQ-032 Reset mid-operation SHALL abort the access with no ack and no further memory write.
- A write already strobed before reset is not undone.

Structure
REQ-033 Shared package mem_arb_pkg SHALL hold the state enum, the BE_FULL/BE_NONE constants and the port-id type.
REQ-034 Byte merge SHALL be a sub-module byte_merge (inputs old, new, be; output merged word).
- Purely combinational; reused by a later load/store unit.

Verification
REQ-035 Single read: p0 read at addr 0x10 with memory word 0xDEADBEEF -> gnt at N, read_en at N+1, p0_ack at N+2 with rdata 0xDEADBEEF.
REQ-036 Tie after reset: p0 and p1 request together -> p0 granted first, p1 granted next at N+3; repeated ties alternate.
REQ-037 Partial write: memory 0x11223344, p1 writes 0xAABBCCDD with be=4'b0101 -> merged write 0x11BB33DD at N+2, p1_ack at N+3.
REQ-038 No-op: be=0 write -> ack at N+2, no write strobe.
REQ-039 Reset asserted in MERGE -> no write strobe, no ack, FSM in IDLE, all outputs 0; after release a pending p0 request is granted.
REQ-040 Address 0x13 -> o_mem_addr = 0x10; held request during busy is granted exactly once.
